clk_div_ctrl: RTL and testbench

- Run-time controller for the lab clock divider: generates a 50%-duty divided clock `clk_div` plus a one-cycle `tick` strobe from the system clock `clk`.
- Adds start/stop control and a valid/ready reconfiguration port to the divider.
- A new divisor takes effect only on a period boundary, so `clk_div` never glitches.
- Sits between the top-level control logic and any consumer of the divided clock or strobe.

---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_core.sv | 42 ++++
 rtl/clk_div_ctrl.sv | 102 ++++++++++
 tb/tb_clk_div_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and defaults for the run-time clock divider
`timescale 1ns/1ps
package clk_div_pkg;

  localparam int CNT_W_DEFAULT    = 16;
  localparam int DEF_HALF_DEFAULT = 5000;
  localparam int MIN_HALF         = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - half-period counter and toggle flop of the divider
`timescale 1ns/1ps
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             restart,
  input  logic [CNT_W-1:0] half,
  output logic             clk_div,
  output logic             rise
);

  logic [CNT_W-1:0] cnt;
  logic             phase_end;

  assign phase_end = (cnt == half - CNT_W'(1));
  // Low phase complete: the next toggle would be a rising edge.
  assign rise      = !clk_div && phase_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      clk_div <= 1'b1;
    end else if (!run) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else if (phase_end) begin
      cnt     <= '0;
      clk_div <= ~clk_div;
    end else begin
      cnt     <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - start/stop FSM and glitch-free reconfiguration around clk_div_core
`timescale 1ns/1ps
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DEF_HALF = DEF_HALF_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
);

  state_e           state, state_nxt;
  logic             core_run, core_restart, core_rise;
  logic             boundary;
  logic             pending;
  logic [CNT_W-1:0] pend_half;
  logic [CNT_W-1:0] cfg_clamped;

  assign cfg_ready   = ~pending;
  assign cfg_clamped = (cfg_half < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : cfg_half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (en) state_nxt = ST_RUN;
      ST_RUN:      if (!en) state_nxt = ST_STOPPING;
      ST_STOPPING: begin
        if (en)             state_nxt = ST_RUN;
        else if (core_rise) state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // A rising boundary is either a start from IDLE or a completed low phase that is allowed to rise.
  always_comb begin
    core_run     = 1'b0;
    core_restart = 1'b0;
    boundary     = 1'b0;
    case (state)
      ST_IDLE: begin
        core_restart = en;
        boundary     = en;
      end
      ST_RUN: begin
        core_run = 1'b1;
        boundary = core_rise;
      end
      ST_STOPPING: begin
        core_run = en || !core_rise;
        boundary = en && core_rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick      <= 1'b0;
      busy      <= 1'b0;
      cur_half  <= CNT_W'(DEF_HALF);
      pend_half <= CNT_W'(MIN_HALF);
      pending   <= 1'b0;
    end else begin
      tick <= boundary;
      busy <= (state_nxt != ST_IDLE);
      // Capture needs pending clear, so it never collides with applying a pending value.
      if (boundary && pending) begin
        cur_half <= pend_half;
        pending  <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
        pend_half <= cfg_clamped;
        pending   <= 1'b1;
      end
    end
  end

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (core_run),
    .restart (core_restart),
    .half    (cur_half),
    .clk_div (clk_div),
    .rise    (core_rise)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl against a phase-level model
`timescale 1ns/1ps
module tb_clk_div_ctrl;

  localparam int CNT_W    = 16;
  localparam int DEF_HALF = 5000;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STOP   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic             cfg_ready, clk_div, tick, busy;
  logic [CNT_W-1:0] cur_half;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, output level, cycles left in the current phase, half in force, pending config.
  int m_mode, m_level, m_left, m_half, m_pend, m_pend_val, m_tick;

  int     rises = 0;
  logic   prev_div = 1'b0;
  longint t_rise = 0, t_rise_prev = 0, t_fall = 0;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_div   (clk_div),
    .tick      (tick),
    .busy      (busy),
    .cur_half  (cur_half)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_level = 0; m_left = 0; m_half = DEF_HALF;
    m_pend = 0; m_pend_val = 1; m_tick = 0;
  endtask

  task automatic model_step();
    int rising;
    int cap;
    rising = 0;
    cap = (cfg_valid && m_pend == 0) ? 1 : 0;
    if (m_mode == M_IDLE) begin
      if (en) begin rising = 1; m_mode = M_RUN; end
    end else begin
      if (m_left == 1) begin
        if (m_level == 1) begin
          m_level = 0; m_left = m_half;
        end else if (m_mode == M_STOP && !en) begin
          m_mode = M_IDLE; m_level = 0; m_left = 0;
        end else begin
          rising = 1;
        end
      end else begin
        m_left--;
      end
      if (m_mode == M_RUN && !en)      m_mode = M_STOP;
      else if (m_mode == M_STOP && en) m_mode = M_RUN;
    end
    if (rising == 1) begin
      if (m_pend == 1) begin m_half = m_pend_val; m_pend = 0; end
      m_level = 1; m_left = m_half;
    end
    m_tick = rising;
    if (cap == 1) begin
      m_pend = 1;
      m_pend_val = (int'(cfg_half) < 2) ? 1 : int'(cfg_half);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("clk_div", int'(clk_div), m_level);
    check("tick", int'(tick), m_tick);
    check("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
    check("cur_half", int'(cur_half), m_half);
    check("cfg_ready", int'(cfg_ready), (m_pend == 0) ? 1 : 0);
    if (clk_div && !prev_div) begin t_rise_prev = t_rise; t_rise = $time; rises++; end
    if (!clk_div && prev_div) t_fall = $time;
    prev_div = clk_div;
  endtask

  task automatic wait_rises(input int n, input int budget);
    int target;
    int k;
    target = rises + n;
    k = 0;
    while (rises < target && k < budget) begin cycle(); k++; end
    if (rises < target) check("rise_timeout", rises, target);
  endtask

  task automatic send_cfg(input int val, input int budget);
    logic acc;
    int   k;
    acc = 1'b0;
    k = 0;
    cfg_half  = CNT_W'(val);
    cfg_valid = 1'b1;
    while (!acc && k < budget) begin
      acc = cfg_ready;
      cycle();
      k++;
    end
    cfg_valid = 1'b0;
    if (!acc) check("cfg_timeout", 0, 1);
  endtask

  initial begin
    int k;
    model_reset();
    #12;
    check("rst_clk_div", int'(clk_div), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cur_half", int'(cur_half), DEF_HALF);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(); cycle();

    // Default run: start latency, full period and high time at DEF_HALF.
    en = 1'b1;
    cycle();
    check("start_latency", int'(clk_div), 1);
    check("start_tick", int'(tick), 1);
    wait_rises(1, 12000);
    check("def_period_ns", int'(t_rise - t_rise_prev), 100000);
    check("def_high_ns", int'(t_fall - t_rise_prev), 50000);

    // Reconfig mid high phase: current period unchanged, next period 20 cycles.
    repeat (2500) cycle();
    send_cfg(10, 4);
    check("reconf_ready_low", int'(cfg_ready), 0);
    check("reconf_half_old", int'(cur_half), DEF_HALF);
    wait_rises(1, 12000);
    check("reconf_cur_period_ns", int'(t_rise - t_rise_prev), 100000);
    check("reconf_half_new", int'(cur_half), 10);
    wait_rises(1, 100);
    check("reconf_new_period_ns", int'(t_rise - t_rise_prev), 200);

    // Clamp 0 -> half 1, then back-to-back offers.
    send_cfg(0, 40);
    wait_rises(2, 100);
    check("clamp_half", int'(cur_half), 1);
    check("clamp_period_ns", int'(t_rise - t_rise_prev), 20);
    send_cfg(3, 10);
    check("b2b_ready_low", int'(cfg_ready), 0);
    send_cfg(6, 40);
    check("b2b_first_applied", int'(cur_half), 3);
    wait_rises(2, 100);
    check("b2b_period_ns", int'(t_rise - t_rise_prev), 120);

    // Stop mid high phase: finish low phase, then idle with no extra tick.
    wait_rises(1, 50);
    cycle(); cycle();
    en = 1'b0;
    k = 0;
    while (busy && k < 40) begin cycle(); k++; end
    check("stop_busy_low", int'(busy), 0);
    check("stop_clk_div_low", int'(clk_div), 0);
    repeat (4) cycle();

    // Restart, then drop and reassert en during the low phase of STOPPING.
    en = 1'b1;
    wait_rises(1, 5);
    cycle(); cycle();
    en = 1'b0;
    k = 0;
    while (m_level == 1 && k < 20) begin cycle(); k++; end
    cycle(); cycle();
    en = 1'b1;
    wait_rises(1, 50);
    check("resume_period_ns", int'(t_rise - t_rise_prev), 120);

    // Capture in the same cycle as a rising boundary.
    send_cfg(4, 20);
    wait_rises(2, 50);
    k = 0;
    while (!(m_mode == M_RUN && m_level == 0 && m_left == 1) && k < 20) begin cycle(); k++; end
    cfg_half  = CNT_W'(7);
    cfg_valid = 1'b1;
    cycle();
    cfg_valid = 1'b0;
    check("simul_tick", int'(tick), 1);
    check("simul_half_old", int'(cur_half), 4);
    wait_rises(1, 50);
    check("simul_old_period_ns", int'(t_rise - t_rise_prev), 80);
    check("simul_half_new", int'(cur_half), 7);
    wait_rises(1, 50);
    check("simul_new_period_ns", int'(t_rise - t_rise_prev), 140);

    // Asynchronous reset in the low phase, off the clock edge.
    k = 0;
    while (!(m_mode == M_RUN && m_level == 0 && m_left > 3) && k < 30) begin cycle(); k++; end
    @(posedge clk);
    model_step();
    #3;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("arst_clk_div", int'(clk_div), 0);
    check("arst_tick", int'(tick), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_cur_half", int'(cur_half), DEF_HALF);
    check("arst_cfg_ready", int'(cfg_ready), 1);
    model_reset();
    prev_div = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Config offered while idle is applied at the next start.
    send_cfg(3, 4);
    cycle();
    en = 1'b1;
    cycle();
    check("idle_cfg_applied", int'(cur_half), 3);

    // Randomized traffic with small half-periods.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_half  = CNT_W'($urandom_range(0, 6));
      cycle();
    end
    cfg_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
